// File: rtl/ram_axis_streamer.sv
// rtl/ram_axis_streamer.sv - Streams SDP RAM words 0..DD-1 as one AXI4-Stream frame per start pulse
//
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   start             one-cycle request to stream a frame
//   busy              high from accepted start until the final beat handshakes
//   done              one-cycle pulse the cycle after the TLAST handshake
//   start_err         one-cycle pulse when start arrives while busy or on the done cycle
//   addrb / dob       RAM read port; dob is valid RD_LATENCY cycles after addrb
//   M_AXIS_TDATA/TVALID/TLAST/TREADY   stream master output

module ram_axis_streamer #(
    parameter int DW         = 512,
    parameter int DD         = 16384,
    parameter int RD_LATENCY = 2,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  start_err,
    output logic [$clog2(DD)-1:0] addrb,
    input  logic [DW-1:0]         dob,
    output logic [DW-1:0]         M_AXIS_TDATA,
    output logic                  M_AXIS_TVALID,
    output logic                  M_AXIS_TLAST,
    input  logic                  M_AXIS_TREADY
);

    localparam int AW = $clog2(DD);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    // Wide enough for inflight (at most RD_LATENCY+1) plus a full FIFO.
    localparam int SW = $clog2(FIFO_DEPTH + RD_LATENCY + 2);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN
    } state_t;

    state_t state_q, state_d;

    logic [AW-1:0] rd_addr_q, rd_addr_d;
    logic [AW-1:0] addrb_q, addrb_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          start_err_q, start_err_d;

    // Tag stage 0 lines up with the registered addrb; stage RD_LATENCY lines
    // up with the cycle in which dob carries that address's data.
    logic [RD_LATENCY:0] tag_valid_q, tag_valid_d;
    logic [RD_LATENCY:0] tag_last_q, tag_last_d;

    logic [DW:0]   fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] fifo_count_q, fifo_count_d;

    logic          issue;
    logic          issue_last;
    logic          accept;
    logic          push;
    logic          pop;
    logic          credit_ok;
    logic [SW-1:0] inflight;
    logic [DW:0]   fifo_head;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // ---------------- stream side ----------------
    assign fifo_head     = fifo_mem[rd_ptr_q];
    assign M_AXIS_TVALID = (fifo_count_q != '0);
    // Gated so the stream is all-zero whenever nothing is offered.
    assign M_AXIS_TDATA  = M_AXIS_TVALID ? fifo_head[DW-1:0] : '0;
    assign M_AXIS_TLAST  = M_AXIS_TVALID & fifo_head[DW];
    assign pop           = M_AXIS_TVALID & M_AXIS_TREADY;
    assign push          = tag_valid_q[RD_LATENCY];

    // ---------------- credit ----------------
    // Every issued read owns a FIFO slot from issue until it is popped, so
    // outstanding tags plus stored words must stay within FIFO_DEPTH. Pops in
    // the current cycle are not credited, which keeps the check off the
    // TREADY path while still allowing one read per cycle at full rate.
    always_comb begin
        inflight = '0;
        for (int i = 0; i <= RD_LATENCY; i++) begin
            inflight = inflight + SW'(tag_valid_q[i]);
        end
    end

    assign credit_ok = (inflight + SW'(fifo_count_q)) < SW'(FIFO_DEPTH);

    // ---------------- control FSM ----------------
    // The done cycle still counts as busy for start acceptance.
    assign accept = start && (state_q == ST_IDLE) && !done_q;

    always_comb begin
        state_d     = state_q;
        rd_addr_d   = rd_addr_q;
        addrb_d     = addrb_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        start_err_d = start && !accept;
        issue       = 1'b0;
        issue_last  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    // Word 0 is issued on the accepting edge so addrb=0 is
                    // presented the very next cycle.
                    issue     = 1'b1;
                    addrb_d   = '0;
                    rd_addr_d = AW'(1);
                    busy_d    = 1'b1;
                    state_d   = ST_READ;
                end
            end

            ST_READ: begin
                if (credit_ok) begin
                    issue   = 1'b1;
                    addrb_d = rd_addr_q;
                    if (rd_addr_q == AW'(DD - 1)) begin
                        issue_last = 1'b1;
                        rd_addr_d  = '0;
                        state_d    = ST_DRAIN;
                    end else begin
                        rd_addr_d = rd_addr_q + AW'(1);
                    end
                end
            end

            ST_DRAIN: begin
                // The tagged-last word is the final FIFO entry, so its
                // handshake also means the FIFO is now empty.
                if (pop && fifo_head[DW]) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ---------------- read pipeline and FIFO bookkeeping ----------------
    always_comb begin
        tag_valid_d  = {tag_valid_q[RD_LATENCY-1:0], issue};
        tag_last_d   = {tag_last_q[RD_LATENCY-1:0], issue_last};
        wr_ptr_d     = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d     = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        fifo_count_d = fifo_count_q;
        case ({push, pop})
            2'b10:   fifo_count_d = fifo_count_q + CW'(1);
            2'b01:   fifo_count_d = fifo_count_q - CW'(1);
            default: fifo_count_d = fifo_count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            rd_addr_q    <= '0;
            addrb_q      <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            start_err_q  <= 1'b0;
            tag_valid_q  <= '0;
            tag_last_q   <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_count_q <= '0;
        end else begin
            state_q      <= state_d;
            rd_addr_q    <= rd_addr_d;
            addrb_q      <= addrb_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            start_err_q  <= start_err_d;
            tag_valid_q  <= tag_valid_d;
            tag_last_q   <= tag_last_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fifo_count_q <= fifo_count_d;
        end
    end

    // Storage needs no reset: entries are only read while fifo_count_q != 0.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {tag_last_q[RD_LATENCY], dob};
        end
    end

    assign addrb     = addrb_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign start_err = start_err_q;

    // A push into a full FIFO without a simultaneous pop would lose a word.
    push_never_overflows: assert property (@(posedge clk) disable iff (reset)
        !(push && !pop && (fifo_count_q == CW'(FIFO_DEPTH))));

endmodule
